// File: rtl/formula_1_arg_pacer_if.sv
// Handshake bundle between the argument producer, the pacer and the formula_1 FSM.
// The producer side is up_*; the issue side is arg_vld with a/b/c.
interface formula_1_arg_pacer_if #(
  parameter int W = 32
);
  logic         up_vld;
  logic         up_rdy;
  logic [W-1:0] up_a;
  logic [W-1:0] up_b;
  logic [W-1:0] up_c;
  logic         arg_vld;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;

  modport master (
    output up_vld, up_a, up_b, up_c,
    input  up_rdy, arg_vld, a, b, c
  );

  modport slave (
    input  up_vld, up_a, up_b, up_c,
    output up_rdy, arg_vld, a, b, c
  );
endinterface

// File: rtl/formula_1_arg_pacer.sv
// Buffers (a,b,c) triples and issues them as arg_vld pulses spaced GAP cycles apart.
// Optional stall counter output enabled by defining FORMULA_1_ARG_PACER_STATS_EN.
//
// state | meaning
// READY | cooldown is 0; issue the FIFO head if there is one
// COOL  | cooldown counting down after an issue; no pulse
module formula_1_arg_pacer #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int GAP   = 19
) (
  input  logic                         clk,
  input  logic                         rst,
  formula_1_arg_pacer_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0]   fill
`ifdef FORMULA_1_ARG_PACER_STATS_EN
  ,
  output logic [15:0]                  stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic {READY, COOL} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cooldown_q, cooldown_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [3*W-1:0]      mem_q [DEPTH];
  logic [3*W-1:0]      mem_d [DEPTH];
  logic                push;
  logic                pop;

  // Handshake outputs are gated by rst so nothing is accepted or issued during reset.
  always_comb begin
    bus.up_rdy  = !rst && (fill_q != FW'(DEPTH));
    bus.arg_vld = !rst && (state_q == READY) && (fill_q != '0);
    {bus.a, bus.b, bus.c} = mem_q[rd_ptr_q];
    push = bus.up_vld && bus.up_rdy;
    pop  = bus.arg_vld;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.up_a, bus.up_b, bus.up_c};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cooldown_d = cooldown_q;
    case (state_q)
      READY: begin
        if (pop) begin
          cooldown_d = CW'(GAP - 1);
          if (GAP > 1) state_d = COOL;
        end
      end
      COOL: begin
        cooldown_d = cooldown_q - CW'(1);
        if (cooldown_q == CW'(1)) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= READY;
      cooldown_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      cooldown_q <= cooldown_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
    end
  end

  // Storage needs no reset: fill gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign fill = fill_q;

`ifdef FORMULA_1_ARG_PACER_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.up_vld && !bus.up_rdy && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule
